lb_conv_sched: RTL and testbench
================================

// Module: lb_conv_sched
// PURPOSE
//  Frame-level scheduler for the 3-line-buffer 3x3 convolution path. Accepts a pixel
//  stream row by row and writes each row into one of three line buffers (LB0..LB2).
//  Once three rows are resident it holds conv_data_valid and the rotation index
//  conv_k for the conv engine until that engine pulses conv_ready at end of row.
//  It then refills the oldest buffer with the next row, repeating until the frame ends.
// PARAMETERS
//  IMG_W  100  pixels per input row; conv engine emits IMG_W-2 outputs per row
//  IMG_H  100  rows per frame; IMG_H-2 conv rows per frame (IMG_H>=3, IMG_W>=3)
//  AW     7    line-buffer address width (IMG_W <= 2**AW)
// PORTS
//  clk              in   1   clock, all logic on posedge
//  rst              in   1   synchronous, active-high reset
//  start            in   1   1-cycle pulse: begin a frame (ignored unless IDLE)
//  pix_valid        in   1   pixel on pix_in valid
//  pix_in           in   8   pixel value (unsigned)
//  pix_ready        out  1   scheduler accepts pixel; transfer = pix_valid & pix_ready
//  lb_wr_en         out  3   one-hot LB write strobe (bit i -> LBi)
//  lb_wr_addr       out  AW  LB write address (column)
//  lb_wr_data       out  8   LB write data
//  conv_data_valid  out  1   three rows resident; level, held for whole conv row
//  conv_k           out  2   rotation: top/mid/bottom = LB[k], LB[(k+1)%3], LB[(k+2)%3]
//  conv_ready       in   1   conv engine end-of-row pulse
//  out_row          out  AW  index of conv row in progress (0..IMG_H-3)
//  busy             out  1   1 in any state but IDLE
//  frame_done       out  1   1-cycle pulse after last conv row completes
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; conv_k=0; column, row and fill counters 0.
//  States: IDLE -> FILL -> CONV -> (FILL | DONE) -> IDLE.
//  IDLE: pix_ready=0. start=1 -> FILL, fill_sel=LB0, rows_in=0, conv_k=0, out_row=0.
//  FILL: pix_ready=1, decoded from state register only (no input->output comb path).
//   On each transfer, at the next edge: lb_wr_en=onehot(fill_sel), lb_wr_addr=col,
//   lb_wr_data=pix_in (1-cycle write latency); col++. Otherwise lb_wr_en=0.
//   Transfer with col==IMG_W-1: col=0, rows_in++, state changes at the same edge,
//   so pix_ready is 0 in the following cycle.
//   Initial fill: fill_sel goes LB0 -> LB1 -> LB2; after the 3rd row -> CONV.
//   Refill (1 row): after the row -> CONV.
//  CONV: pix_ready=0; conv_data_valid=1 for every cycle in CONV, conv_k stable.
//   On conv_ready:
//    - if out_row==IMG_H-3 -> DONE.
//    - else fill_sel=conv_k (oldest row), conv_k=(conv_k+1)%3, out_row++, -> FILL.
//   conv_data_valid falls in the cycle after conv_ready.
//  DONE: frame_done=1 for exactly one cycle -> IDLE; conv_k/out_row keep final values.
//  Boundaries:
//   - start while busy: ignored.
//   - conv_ready outside CONV: ignored.
//   - pix_valid outside FILL: not accepted, no write.
//   - conv_ready and pix_valid in the same cycle: no write; the pixel waits for FILL.
//   - conv_k wraps 2->0.
//   - rst mid-frame: IDLE next cycle, lb_wr_en=0, conv_data_valid=0; partial row discarded.
//  No arithmetic beyond counters; all counters wrap-free by construction of parameters.
// TESTING (IMG_W=4, IMG_H=5 unless stated)
//  1 rst, start, 12 back-to-back pixels 1..12 -> LB0<=1..4, LB1<=5..8, LB2<=9..12,
//    addr 0..3 each; conv_data_valid=1, conv_k=0 the cycle after pixel 12.
//  2 conv_ready, then pixels 13..16 -> written to LB0 only; conv_k=1, out_row=1;
//    next conv_ready -> LB1 refilled, conv_k=2.
//  3 complete frame: 3 conv_ready pulses -> frame_done 1 cycle after the 3rd,
//    busy=0 next, conv_k=2.
//  4 pix_valid toggling 1/0 during fill, plus pix_valid held 1 in CONV -> no writes in
//    CONV; column count exact; no pixel lost or duplicated.
//  5 rst asserted after pixel 6 -> IDLE next cycle, outputs 0; new start refills from
//    LB0 addr 0.
//  6 start and conv_ready pulsed while in CONV/FILL -> no state or counter change.

Source files
------------

// File: rtl/lb_conv_sched.sv
// Frame scheduler for the 3-line-buffer 3x3 convolution path: fills LB0..LB2 row by row,
// then alternates one conv row with one refill of the oldest buffer until the frame ends.
module lb_conv_sched #(
    parameter int IMG_W = 100,
    parameter int IMG_H = 100,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pix_valid,
    input  logic [7:0]    pix_in,
    output logic          pix_ready,
    output logic [2:0]    lb_wr_en,
    output logic [AW-1:0] lb_wr_addr,
    output logic [7:0]    lb_wr_data,
    output logic          conv_data_valid,
    output logic [1:0]    conv_k,
    input  logic          conv_ready,
    output logic [AW-1:0] out_row,
    output logic          busy,
    output logic          frame_done
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_CONV, S_DONE} state_t;

    localparam logic [AW-1:0] LAST_COL = AW'(IMG_W - 1);
    localparam logic [AW-1:0] LAST_ROW = AW'(IMG_H - 3);

    state_t        state;
    logic [AW-1:0] col;
    logic [1:0]    rows_in;
    logic [1:0]    fill_sel;

    // Handshake and status are pure decodes of the state register.
    assign pix_ready       = (state == S_FILL);
    assign conv_data_valid = (state == S_CONV);
    assign busy            = (state != S_IDLE);
    assign frame_done      = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            col        <= '0;
            rows_in    <= '0;
            fill_sel   <= '0;
            conv_k     <= '0;
            out_row    <= '0;
            lb_wr_en   <= '0;
            lb_wr_addr <= '0;
            lb_wr_data <= '0;
        end else begin
            lb_wr_en <= '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FILL;
                        col      <= '0;
                        rows_in  <= '0;
                        fill_sel <= '0;
                        conv_k   <= '0;
                        out_row  <= '0;
                    end
                end
                S_FILL: begin
                    if (pix_valid) begin
                        lb_wr_en   <= 3'b001 << fill_sel;
                        lb_wr_addr <= col;
                        lb_wr_data <= pix_in;
                        if (col == LAST_COL) begin
                            col <= '0;
                            // rows_in saturates at 2, so every refill is a single row
                            if (rows_in == 2'd2) begin
                                state <= S_CONV;
                            end else begin
                                rows_in  <= rows_in + 2'd1;
                                fill_sel <= fill_sel + 2'd1;
                            end
                        end else begin
                            col <= col + AW'(1);
                        end
                    end
                end
                S_CONV: begin
                    if (conv_ready) begin
                        if (out_row == LAST_ROW) begin
                            state <= S_DONE;
                        end else begin
                            fill_sel <= conv_k;
                            conv_k   <= (conv_k == 2'd2) ? 2'd0 : conv_k + 2'd1;
                            out_row  <= out_row + AW'(1);
                            state    <= S_FILL;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lb_conv_sched.sv
// Scoreboard bench for lb_conv_sched: frame row r lands in LB[r%3], conv row j uses k=j%3;
// a negedge monitor pops expected writes, conv-row starts and frame_done events.
module tb_lb_conv_sched;

    localparam int IMG_W = 4;
    localparam int IMG_H = 6;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst, start, pix_valid, conv_ready;
    logic [7:0]    pix_in;
    logic          pix_ready, conv_data_valid, busy, frame_done;
    logic [2:0]    lb_wr_en;
    logic [AW-1:0] lb_wr_addr, out_row;
    logic [7:0]    lb_wr_data;
    logic [1:0]    conv_k;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [3+AW+8-1:0] wr_q[$];
    int conv_k_q[$];
    int conv_row_q[$];
    int done_k_q[$];

    always #5 clk = ~clk;

    lb_conv_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .pix_valid(pix_valid), .pix_in(pix_in), .pix_ready(pix_ready),
        .lb_wr_en(lb_wr_en), .lb_wr_addr(lb_wr_addr), .lb_wr_data(lb_wr_data),
        .conv_data_valid(conv_data_valid), .conv_k(conv_k), .conv_ready(conv_ready),
        .out_row(out_row), .busy(busy), .frame_done(frame_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event occurred=0/1 mismatch (got unexpected or missing, required consistent)", name);
    endtask

    function automatic int row_base(input int base, input int r);
        return (base < 0) ? -1 : base + r * IMG_W;
    endfunction

    // Feeds n pixels of frame row r; the model records each accepted pixel as an expected write.
    task automatic feed_row(input int r, input int n, input int base, input int gap, input bit noise);
        for (int c = 0; c < n; c++) begin
            logic [7:0] px;
            int guard;
            bit sent;
            px    = (base >= 0) ? 8'(base + c) : 8'($urandom);
            guard = 0;
            sent  = 1'b0;
            while (!sent) begin
                pix_in     = px;
                pix_valid  = (int'($urandom_range(0, 99)) >= gap);
                start      = noise && ($urandom_range(0, 9) == 0);
                conv_ready = noise && ($urandom_range(0, 9) == 0);
                if (pix_valid && pix_ready) begin
                    wr_q.push_back({3'(1 << (r % 3)), AW'(c), px});
                    sent = 1'b1;
                end
                @(negedge clk);
                if (!sent) begin
                    guard++;
                    if (guard > 100) begin
                        fail_now("feed_timeout");
                        start = 1'b0; conv_ready = 1'b0; pix_valid = 1'b0;
                        return;
                    end
                end
            end
        end
        start      = 1'b0;
        conv_ready = 1'b0;
        pix_valid  = 1'b0;
    endtask

    task automatic run_frame(input int base, input int gap, input bit noise);
        start = 1'b1; conv_ready = 1'b0; pix_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("ready_in_fill", pix_ready, 1);
        conv_k_q.push_back(0);
        conv_row_q.push_back(0);
        for (int r = 0; r < 3; r++) feed_row(r, IMG_W, row_base(base, r), gap, noise);
        for (int j = 0; j <= IMG_H - 3; j++) begin
            int w;
            w = int'($urandom_range(1, 4));
            for (int i = 0; i < w; i++) begin
                pix_valid  = noise ? 1'($urandom_range(0, 1)) : 1'b1;
                pix_in     = 8'($urandom);
                start      = noise && ($urandom_range(0, 3) == 0);
                conv_ready = 1'b0;
                @(negedge clk);
            end
            start = 1'b0;
            if (j == IMG_H - 3) done_k_q.push_back(j % 3);
            conv_ready = 1'b1;
            pix_valid  = 1'b1;
            @(negedge clk);
            conv_ready = 1'b0;
            pix_valid  = 1'b0;
            chk("cdv_fall", conv_data_valid, 0);
            if (j == IMG_H - 3) begin
                @(negedge clk);
                chk("idle_busy", busy, 0);
                chk("done_one_cycle", frame_done, 0);
                chk("final_k", conv_k, j % 3);
            end else begin
                chk("refill_ready", pix_ready, 1);
                conv_k_q.push_back((j + 1) % 3);
                conv_row_q.push_back(j + 1);
                feed_row(j + 3, IMG_W, row_base(base, j + 3), gap, noise);
            end
        end
    endtask

    bit prev_cdv = 1'b0;
    int cur_k    = 0;

    always @(negedge clk) begin
        if (lb_wr_en !== 3'b000) begin
            if (wr_q.size() == 0) fail_now("unexpected_write");
            else chk("write", {lb_wr_en, lb_wr_addr, lb_wr_data}, wr_q.pop_front());
        end
        if (conv_data_valid && !prev_cdv) begin
            if (conv_k_q.size() == 0 || conv_row_q.size() == 0) begin
                fail_now("unexpected_conv_row");
            end else begin
                cur_k = conv_k_q.pop_front();
                chk("conv_k_start", conv_k, cur_k);
                chk("out_row", out_row, conv_row_q.pop_front());
                chk("cdv_with_last_wr", {lb_wr_en != 3'b000, lb_wr_addr}, {1'b1, AW'(IMG_W - 1)});
            end
        end
        if (conv_data_valid) begin
            chk("k_stable", conv_k, cur_k);
            chk("no_ready_in_conv", pix_ready, 0);
        end
        if (frame_done) begin
            if (done_k_q.size() == 0) fail_now("unexpected_frame_done");
            else begin
                chk("done_k", conv_k, done_k_q.pop_front());
                chk("done_out_row", out_row, IMG_H - 3);
            end
        end
        prev_cdv = conv_data_valid;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = '0; conv_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", lb_wr_en, 0);
        chk("rst_wr_addr", lb_wr_addr, 0);
        chk("rst_wr_data", lb_wr_data, 0);
        chk("rst_ready", pix_ready, 0);
        chk("rst_cdv", conv_data_valid, 0);
        chk("rst_k", conv_k, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        rst = 1'b0;
        @(negedge clk);

        pix_valid = 1'b1;
        @(negedge clk);
        chk("idle_ignores_pixel", busy, 0);
        pix_valid = 1'b0;

        run_frame(1, 0, 1'b0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed_row(0, IMG_W, 1, 0, 1'b0);
        feed_row(1, 2, 5, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_wr_en", lb_wr_en, 0);
        chk("midrst_cdv", conv_data_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", pix_ready, 0);
        chk("midrst_out_row", out_row, 0);

        run_frame(101, 0, 1'b0);
        run_frame(-1, 50, 1'b0);
        for (int f = 0; f < 5; f++) run_frame(-1, int'($urandom_range(0, 60)), 1'b1);

        repeat (3) @(negedge clk);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("conv_q_empty", conv_k_q.size(), 0);
        chk("done_q_empty", done_k_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
